// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the IF/MEM RAM port arbiter
package mem_arbiter_pkg;

    localparam logic [1:0]  MEM_BYTE  = 2'b00;
    localparam logic [1:0]  MEM_HALF  = 2'b01;
    localparam logic [1:0]  MEM_WORD  = 2'b10;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    // Number of byte transactions for a MEM width code; 11 behaves as a word.
    function automatic logic [2:0] width_len(input logic [1:0] width);
        case (width)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            MEM_WORD: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// rtl/mem_arbiter_byte_assembler.sv - collects RAM read bytes into a little-endian 32-bit word
module mem_arbiter_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        cap_en,
    input  logic [1:0]  idx,
    input  logic [7:0]  din,
    output logic [31:0] data_next
);

    logic [31:0] data_q;

    // Insert the incoming byte into its lane; the owner samples data_next on the final capture.
    always_comb begin
        data_next = data_q;
        if (cap_en) begin
            case (idx)
                2'd0:    data_next[7:0]   = din;
                2'd1:    data_next[15:8]  = din;
                2'd2:    data_next[23:16] = din;
                default: data_next[31:24] = din;
            endcase
        end
    end

    // Clear on grant so narrow loads come out zero-extended.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_q <= ZERO_WORD;
        end else begin
            data_q <= data_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates the byte-wide RAM port between instruction fetch and the MEM stage
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_inst,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_t            state;
    owner_t            owner;
    logic [ADDR_W-1:0] base;
    logic [2:0]        len;
    logic [2:0]        cnt;
    logic              we;
    logic [31:0]       wdata;

    logic              grant_mem;
    logic              grant_if;
    logic              if_cancel;
    logic              addr_phase;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       asm_next;

    // MEM wins over IF; a flushed IF request is never granted.
    assign grant_mem  = (state == ST_IDLE) && mem_req;
    assign grant_if   = (state == ST_IDLE) && !mem_req && if_req && !if_flush;
    assign if_cancel  = (state == ST_BUSY) && (owner == OWN_IF) && if_flush;

    // cnt < len drives an address; a read spends one extra cycle (cnt == len) capturing only.
    assign addr_phase = (state == ST_BUSY) && (cnt < len);
    assign cap_en     = (state == ST_BUSY) && !we && (cnt != 3'd0);
    // RAM data lags the address by one cycle, so the byte lane is cnt-1 (4 wraps to lane 3).
    assign cap_idx    = cnt[1:0] - 2'd1;

    assign ram_a      = addr_phase ? (base + ADDR_W'(cnt)) : '0;
    assign ram_wr     = addr_phase && we;

    assign if_done      = (state == ST_DONE) && (owner == OWN_IF) && !if_flush;
    assign mem_done     = (state == ST_DONE) && (owner == OWN_MEM);
    assign stallreq_if  = if_req && !if_done && !if_flush;
    assign stallreq_mem = mem_req && !mem_done;

    // Select the store byte for the current count; idle bus is held at zero.
    always_comb begin
        ram_dout = 8'h00;
        if (addr_phase && we) begin
            case (cnt[1:0])
                2'd0:    ram_dout = wdata[7:0];
                2'd1:    ram_dout = wdata[15:8];
                2'd2:    ram_dout = wdata[23:16];
                default: ram_dout = wdata[31:24];
            endcase
        end
    end

    mem_arbiter_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (grant_mem || grant_if),
        .cap_en    (cap_en),
        .idx       (cap_idx),
        .din       (ram_din),
        .data_next (asm_next)
    );

    // Arbitration FSM: latch the winner's request at grant, walk the bytes, pulse done once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            base      <= '0;
            len       <= 3'd0;
            cnt       <= 3'd0;
            we        <= 1'b0;
            wdata     <= ZERO_WORD;
            if_inst   <= ZERO_WORD;
            mem_rdata <= ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= 3'd0;
                    if (grant_mem) begin
                        state <= ST_BUSY;
                        owner <= OWN_MEM;
                        base  <= mem_addr;
                        len   <= width_len(mem_width);
                        we    <= mem_we;
                        wdata <= mem_wdata;
                    end else if (grant_if) begin
                        state <= ST_BUSY;
                        owner <= OWN_IF;
                        base  <= if_addr;
                        len   <= 3'd4;
                        we    <= 1'b0;
                        wdata <= ZERO_WORD;
                    end
                end
                ST_BUSY: begin
                    if (if_cancel) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                        cnt   <= 3'd0;
                    end else if (we) begin
                        if (cnt == len - 3'd1) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end else if (cnt == len) begin
                        state <= ST_DONE;
                        if (owner == OWN_IF) begin
                            if_inst <= asm_next;
                        end else begin
                            mem_rdata <= asm_next;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_flush = 1'b0;
    logic [31:0]       if_inst;
    logic              if_done;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_width = 2'b00;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [7:0]        ram_din = 8'h00;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_inst      (if_inst),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_width    (mem_width),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .ram_a        (ram_a),
        .ram_wr       (ram_wr)
    );

    // RAM model: sparse image folded into 8K entries, registered read, logged writes.
    bit [7:0]    ram_mem [8192];
    bit          ram_vld [8192];
    logic [31:0] wlog_addr [64];
    logic [7:0]  wlog_data [64];
    int          wlog_n = 0;

    function automatic logic [12:0] ram_idx(input logic [31:0] a);
        return {a[15:12], a[8:0]};
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0010: return 8'h80;
            32'h0000_0200: return 8'h78;
            32'h0000_0201: return 8'h56;
            32'h0000_0202: return 8'h34;
            32'h0000_0203: return 8'h12;
            32'hFFFF_FFFF: return 8'h11;
            32'h0000_0000: return 8'h22;
            default:       return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        ram_din <= ram_vld[ram_idx(ram_a)] ? ram_mem[ram_idx(ram_a)] : init_byte(ram_a);
        if (ram_wr) begin
            ram_mem[ram_idx(ram_a)] <= ram_dout;
            ram_vld[ram_idx(ram_a)] <= 1'b1;
            wlog_addr[wlog_n[5:0]]  <= ram_a;
            wlog_data[wlog_n[5:0]]  <= ram_dout;
            wlog_n                  <= wlog_n + 1;
        end
    end

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic run_txn(input int id, input vec_t v);
        int          n;
        int          lat;
        int          wbase;
        logic [31:0] rdata;
        logic [31:0] a_log [4];
        logic        wr_log [4];
        n     = v.is_mem ? nbytes(v.width) : 4;
        wbase = wlog_n;
        lat   = 0;
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            a_log[i]  = '0;
            wr_log[i] = 1'b0;
        end
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_width = v.width;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c <= n) begin
                a_log[c-1]  = ram_a;
                wr_log[c-1] = ram_wr;
            end
            if ((v.is_mem && mem_done) || (!v.is_mem && if_done)) begin
                lat   = c;
                rdata = v.is_mem ? mem_rdata : if_inst;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_idle_ram_a", id), ram_a, 32'h0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("v%0d_ram_a%0d", id, i), a_log[i], v.addr + 32'(i));
            chk($sformatf("v%0d_ram_wr%0d", id, i), 32'(wr_log[i]), 32'(v.we));
        end
        if (v.we) begin
            chk($sformatf("v%0d_write_count", id), 32'(wlog_n - wbase), 32'(n));
            for (int i = 0; i < n; i++) begin
                chk($sformatf("v%0d_wlog_addr%0d", id, i), wlog_addr[(wbase + i) % 64], v.addr + 32'(i));
                chk($sformatf("v%0d_wlog_data%0d", id, i), 32'(wlog_data[(wbase + i) % 64]),
                    (v.wdata >> (8 * i)) & 32'hFF);
            end
        end else begin
            chk($sformatf("v%0d_rdata", id), rdata, v.exp_rdata);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_single", id), 32'(if_done | mem_done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          md_cyc;
        int          id_cyc;
        int          early;
        int          lat;
        int          wbase;
        logic [31:0] a_first;
        logic [31:0] a_if;
        logic [31:0] rd_m;
        logic [31:0] rd_i;
        vec_t        tv;

        //           is_mem we    width  addr           wdata          exp_rdata      lat
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h0000_0013, 6};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h0000_2001, 32'h0,         32'h0000_00BE, 3};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 32'h0000_3001, 32'h1234_ABCD, 32'h0,         3};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 32'h0000_3001, 32'h0,         32'h0000_ABCD, 4};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_2211, 4};
        vecs[7]  = '{1'b1, 1'b1, 2'b11, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         5};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 6};
        vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0050, 32'h0055_AA77, 32'h0,         2};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 32'h0000_0050, 32'h0,         32'h0000_0077, 3};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h0000_004E, 32'h0,         32'h0077_0000, 6};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_wr", 32'(ram_wr), 32'h0);
        chk("rst_ram_dout", 32'(ram_dout), 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_dones", 32'({if_done, mem_done}), 32'h0);
        chk("rst_stalls", 32'({stallreq_if, stallreq_mem}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_txn(i, vecs[i]);
        end

        // Simultaneous requests: MEM byte load first, IF fetch right after DONE->IDLE.
        if_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_width = 2'b00;
        mem_addr  = 32'h0000_0010;
        #1;
        chk("arb_stall_if", 32'(stallreq_if), 32'h1);
        chk("arb_stall_mem", 32'(stallreq_mem), 32'h1);
        md_cyc  = 0;
        id_cyc  = 0;
        early   = 0;
        a_first = '0;
        a_if    = '0;
        rd_m    = '0;
        rd_i    = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) a_first = ram_a;
            if (c == 5) a_if = ram_a;
            if (if_done && md_cyc == 0) early++;
            if (mem_done) begin
                md_cyc = c;
                rd_m   = mem_rdata;
                chk("arb_stall_mem_at_done", 32'(stallreq_mem), 32'h0);
                chk("arb_stall_if_during_mem", 32'(stallreq_if), 32'h1);
                mem_req = 1'b0;
            end
            if (if_done) begin
                id_cyc = c;
                rd_i   = if_inst;
                if_req = 1'b0;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        chk("arb_first_addr", a_first, 32'h0000_0010);
        chk("arb_mem_done_cycle", 32'(md_cyc), 32'd3);
        chk("arb_mem_rdata", rd_m, 32'h0000_0080);
        chk("arb_if_early_done", 32'(early), 32'h0);
        chk("arb_if_addr", a_if, 32'h0000_0100);
        chk("arb_if_done_cycle", 32'(id_cyc), 32'd10);
        chk("arb_if_inst", rd_i, 32'h0000_0013);
        @(posedge clk); #1;

        // Flush at cnt=2 of an IF read, then refetch from the redirected address.
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        early   = 0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (if_done) early++;
        end
        if_flush = 1'b1;
        if_addr  = 32'h0000_0200;
        #1;
        chk("flush_stall_if", 32'(stallreq_if), 32'h0);
        @(posedge clk); #1;
        if (if_done) early++;
        chk("flush_idle_ram_a", ram_a, 32'h0);
        if_flush = 1'b0;
        lat      = 0;
        a_first  = '0;
        rd_i     = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) a_first = ram_a;
            if (if_done) begin
                lat    = c;
                rd_i   = if_inst;
                if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0;
        chk("flush_no_done", 32'(early), 32'h0);
        chk("flush_refetch_addr", a_first, 32'h0000_0200);
        chk("flush_refetch_latency", 32'(lat), 32'd6);
        chk("flush_refetch_inst", rd_i, 32'h1234_5678);
        @(posedge clk); #1;

        // Flush coinciding with the IF DONE cycle suppresses if_done.
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        early   = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (if_done) early++;
        end
        @(posedge clk); #1;
        if_flush = 1'b1;
        #1;
        chk("done_flush_pre", 32'(early), 32'h0);
        chk("done_flush_suppressed", 32'(if_done), 32'h0);
        chk("done_flush_inst", if_inst, 32'h0000_0013);
        if_req   = 1'b0;
        if_flush = 1'b0;
        @(posedge clk); #1;
        chk("done_flush_after", 32'(if_done), 32'h0);

        // Reset in the middle of a MEM word store.
        wbase     = wlog_n;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_width = 2'b10;
        mem_addr  = 32'h0000_3000;
        mem_wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid_wr_before", 32'(ram_wr), 32'h1);
        rst     = 1'b1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ram_wr", 32'(ram_wr), 32'h0);
        chk("rstmid_ram_a", ram_a, 32'h0);
        chk("rstmid_ram_dout", 32'(ram_dout), 32'h0);
        chk("rstmid_mem_done", 32'(mem_done), 32'h0);
        chk("rstmid_if_inst", if_inst, 32'h0);
        chk("rstmid_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_mem_done_after", 32'(mem_done), 32'h0);
        chk("rstmid_write_count", 32'(wlog_n - wbase), 32'd2);
        tv = '{1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h0000_0080, 3};
        run_txn(12, tv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
